truth_table_probe: RTL and testbench
====================================

TRUTH_TABLE_PROBE -- requirements
Module: truth_table_probe

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles the DUT is given to settle per input vector before sampling; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request one truth-table sweep; sampled only in IDLE.
REQ-005 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-006 SHALL have port done  output  1  one-cycle pulse when the sweep completes.
REQ-007 SHALL have port code  output  8  recovered truth-table code, e.g. 8'h55.
REQ-008 SHALL have port unstable  output  8  per-vector instability flags (see Configuration).
REQ-009 SHALL have ports dut_in1, dut_in2, dut_in3  output  1 each  drive the 3-input logic block under test.
REQ-010 SHALL have port dut_out  input  1  output of the block under test; treated as synchronous to clk.

Function
REQ-011 SHALL implement FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-012 In IDLE with start=1 at a rising edge, the FSM SHALL clear code and unstable, set vector index i=0, load the settle counter with SETTLE_CYCLES, and enter SETTLE.
REQ-013 {dut_in1,dut_in2,dut_in3} SHALL equal i while in SETTLE and SAMPLE, and 3'b000 otherwise.
REQ-014 SETTLE SHALL last exactly SETTLE_CYCLES cycles, followed by one SAMPLE cycle.
REQ-015 In SAMPLE, the FSM SHALL write dut_out into code[7-i], so that input 3'b000 maps to the MSB and input 3'b111 maps to the LSB.
REQ-016 After SAMPLE, if i<7 the FSM SHALL increment i, reload the counter and re-enter SETTLE; if i=7 it SHALL enter DONE.
REQ-017 DONE SHALL last one cycle with done=1 and SHALL then return to IDLE.
REQ-018 busy SHALL be 1 in SETTLE, SAMPLE and DONE, and 0 in IDLE.
REQ-019 Sweep latency SHALL be 8*(SETTLE_CYCLES+1) cycles from the accepting edge to DONE entry; with default SETTLE_CYCLES=4, done SHALL be high on cycle 41 after the accepting edge.
REQ-020 start while busy=1 SHALL be ignored; start held high in IDLE after DONE SHALL begin a new sweep on the next edge.
REQ-021 code and unstable SHALL hold their final values until the next accepted start; partial values are visible during a sweep but are valid only from done onward.
REQ-022 The index i SHALL be 3 bits and SHALL NOT wrap within a sweep; the counter width SHALL be 8 bits.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, busy=0, done=0, code=8'h00, unstable=8'h00 and dut_in*=0, including mid-sweep; the aborted sweep SHALL NOT resume.
REQ-024 After rst is released, the first sweep SHALL start only on a new start in IDLE.

Configuration
REQ-025 Macro TT_PROBE_SETTLE_CHECK_EN, when defined, SHALL register dut_out on the last SETTLE cycle and compare it with the SAMPLE value; a mismatch SHALL set unstable[7-i].
REQ-026 Without TT_PROBE_SETTLE_CHECK_EN, unstable SHALL be constant 8'h00 and no compare logic SHALL be built; code and timing SHALL be identical in both builds.

Structure
REQ-027 A shared package tt_probe_pkg SHALL hold the FSM state enum, the vector count constant (8), and the counter width constant (8).
REQ-028 The settle countdown SHALL be a sub-module tt_settle_timer (load, count, expire pulse); everything else SHALL be flat.

Verification
REQ-029 DUT out=in3 (function 0x55), SETTLE_CYCLES=4, pulse start -> done on cycle 41, code=8'h55, unstable=8'h00.
REQ-030 DUT AND3 -> code=8'h01; DUT constant 0 -> code=8'h00; DUT constant 1 -> code=8'hFF.
REQ-031 start pulsed again at cycle 10 of a sweep -> ignored, done fires once at cycle 41, and start in the cycle after done begins a second sweep.
REQ-032 rst asserted at cycle 15 mid-sweep -> same-cycle busy=0, code=8'h00, dut_in=3'b000; no done until a new start.
REQ-033 With TT_PROBE_SETTLE_CHECK_EN, DUT glitches dut_out only at the SAMPLE of vector 3'b010 -> unstable=8'h20 and code bit 5 equals the SAMPLE value.
REQ-034 SETTLE_CYCLES=1 -> done on cycle 17 and the correct code for the 0x55 DUT.

Source files
------------

// File: rtl/tt_probe_pkg.sv
// Shared types and constants for the truth-table probe.
// Used by truth_table_probe and tt_settle_timer.
package tt_probe_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  localparam int unsigned NumVectors = 8;
  localparam int unsigned CntWidth   = 8;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle countdown: load with SETTLE_CYCLES, decrement while counting,
// and pulse expire on the last counted cycle.
module tt_settle_timer
  import tt_probe_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CntWidth'(SETTLE_CYCLES);
    end else if (count && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = count && (cnt_q == CntWidth'(1));

endmodule

// File: rtl/truth_table_probe.sv
// Sweeps all 8 input vectors of a 3-input block and recovers its truth-table code.
// Optional settle-stability check enabled by defining TT_PROBE_SETTLE_CHECK_EN.
module truth_table_probe
  import tt_probe_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic [7:0] unstable,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       dut_in3,
  input  logic       dut_out
);

  localparam logic [2:0] LastIdx = 3'(NumVectors - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q;
  logic [7:0] code_q;
  logic       tmr_load, tmr_count, tmr_expire;
  logic       accept, sampling;

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .count (tmr_count),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StSettle;
          tmr_load = 1'b1;
        end
      end
      StSettle: begin
        tmr_count = 1'b1;
        if (tmr_expire) state_d = StSample;
      end
      StSample: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          state_d  = StSettle;
          tmr_load = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign accept   = (state_q == StIdle) && start;
  assign sampling = (state_q == StSample);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q  <= '0;
        code_q <= '0;
      end else if (sampling) begin
        // Vector 000 lands in the MSB, 111 in the LSB.
        code_q[LastIdx - idx_q] <= dut_out;
        if (idx_q != LastIdx) idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef TT_PROBE_SETTLE_CHECK_EN
  logic       settle_val_q;
  logic [7:0] unstable_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_val_q <= 1'b0;
      unstable_q   <= '0;
    end else begin
      if (tmr_expire) settle_val_q <= dut_out;
      if (accept) begin
        unstable_q <= '0;
      end else if (sampling && (settle_val_q != dut_out)) begin
        unstable_q[LastIdx - idx_q] <= 1'b1;
      end
    end
  end

  assign unstable = unstable_q;
`else
  assign unstable = 8'h00;
`endif

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    code = code_q;
    if ((state_q == StSettle) || (state_q == StSample)) begin
      {dut_in1, dut_in2, dut_in3} = idx_q;
    end else begin
      {dut_in1, dut_in2, dut_in3} = 3'b000;
    end
  end

endmodule

// File: tb/tb_truth_table_probe.sv
// Self-checking bench for truth_table_probe: table of modelled logic blocks plus
// hand-written sequences for restart, mid-sweep reset and SETTLE_CYCLES=1.
module tb_truth_table_probe;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, busy, done;
  logic [7:0] code, unstable;
  logic       dut_in1, dut_in2, dut_in3, dut_out;
  logic       start1, busy1, done1;
  logic [7:0] code1, unstable1;
  logic       d1_in1, d1_in2, d1_in3;
  logic       d1_out;

  int         fsel;
  logic       glitch;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  truth_table_probe dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .code    (code),
    .unstable(unstable),
    .dut_in1 (dut_in1),
    .dut_in2 (dut_in2),
    .dut_in3 (dut_in3),
    .dut_out (dut_out)
  );

  truth_table_probe #(
    .SETTLE_CYCLES(1)
  ) dut1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .busy    (busy1),
    .done    (done1),
    .code    (code1),
    .unstable(unstable1),
    .dut_in1 (d1_in1),
    .dut_in2 (d1_in2),
    .dut_in3 (d1_in3),
    .dut_out (d1_out)
  );

  // Model of the block under test, selectable function.
  always_comb begin
    logic f;
    f = 1'b0;
    case (fsel)
      0:       f = dut_in3;
      1:       f = dut_in1 & dut_in2 & dut_in3;
      2:       f = 1'b0;
      3:       f = 1'b1;
      4:       f = dut_in1;
      5:       f = dut_in1 ^ dut_in2 ^ dut_in3;
      default: f = 1'b0;
    endcase
    dut_out = f ^ glitch;
  end

  assign d1_out = d1_in3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge. Runs 45 cycles from the accepting edge; cycle c is the
  // interval after edge c-1 (accepting edge = edge 0).
  task automatic run_sweep(input int f, input int glitch_vec, input int pulse_at,
                           input int restart_at, output int lat, output int dones);
    fsel  = f;
    start = 1'b1;
    @(posedge clk);
    lat   = -1;
    dones = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start  = (c == pulse_at) || (c == restart_at);
      glitch = (c == glitch_vec * 5 + 5);
      if (c == 12) chk("dut_in_vec2", {29'd0, dut_in1, dut_in2, dut_in3}, 32'd2);
      if (done) begin
        dones++;
        if (lat < 0) lat = c;
      end
    end
    start  = 1'b0;
    glitch = 1'b0;
  endtask

  typedef struct {
    int         f;
    logic [7:0] exp_code;
    string      name;
  } vec_t;

  vec_t vecs[6];
  int   lat, dones, n;

  initial begin
    vecs[0] = '{0, 8'h55, "in3"};
    vecs[1] = '{1, 8'h01, "and3"};
    vecs[2] = '{2, 8'h00, "const0"};
    vecs[3] = '{3, 8'hFF, "const1"};
    vecs[4] = '{4, 8'h0F, "in1"};
    vecs[5] = '{5, 8'h69, "xor3"};

    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    fsel   = 0;
    glitch = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_unstable", 32'(unstable), 32'd0);
    chk("rst_dut_in", {29'd0, dut_in1, dut_in2, dut_in3}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      run_sweep(vecs[k].f, -1, 0, 0, lat, dones);
      chk({vecs[k].name, "_latency"}, 32'(lat), 32'd41);
      chk({vecs[k].name, "_dones"}, 32'(dones), 32'd1);
      chk({vecs[k].name, "_code"}, 32'(code), 32'(vecs[k].exp_code));
      chk({vecs[k].name, "_unstable"}, 32'(unstable), 32'd0);
      chk({vecs[k].name, "_idle"}, 32'(busy), 32'd0);
    end

    // start at cycle 10 ignored; start in cycle 42 opens a second sweep.
    run_sweep(0, -1, 10, 42, lat, dones);
    chk("restart_latency", 32'(lat), 32'd41);
    chk("restart_dones", 32'(dones), 32'd1);
    chk("restart_busy", 32'(busy), 32'd1);
    n = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done) begin
        n = c;
        break;
      end
    end
    chk("second_sweep_done", 32'(n), 32'd38);
    chk("second_sweep_code", 32'(code), 32'h55);
    @(negedge clk);

    // Reset at cycle 15 of a sweep.
    fsel  = 0;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("partial_code", 32'(code), 32'h40);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_code", 32'(code), 32'd0);
    chk("midrst_dut_in", {29'd0, dut_in1, dut_in2, dut_in3}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("no_resume", 32'(n), 32'd0);
    run_sweep(0, -1, 0, 0, lat, dones);
    chk("post_rst_latency", 32'(lat), 32'd41);
    chk("post_rst_code", 32'(code), 32'h55);

`ifdef TT_PROBE_SETTLE_CHECK_EN
    run_sweep(0, 2, 0, 0, lat, dones);
    chk("glitch_unstable", 32'(unstable), 32'h20);
    chk("glitch_code", 32'(code), 32'h75);
    run_sweep(0, -1, 0, 0, lat, dones);
    chk("clean_unstable", 32'(unstable), 32'h00);
`endif

    // SETTLE_CYCLES=1 instance.
    start1 = 1'b1;
    @(posedge clk);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1 && n < 0) n = c;
    end
    chk("s1_latency", 32'(n), 32'd17);
    chk("s1_code", 32'(code1), 32'h55);
    chk("s1_unstable", 32'(unstable1), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
